rp32_ifu: RTL and testbench

RP32_IFU -- requirements
Module: rp32_ifu

---
 rtl/rp32_ifu.sv | 83 ++++++++
 tb/tb_rp32_ifu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rp32_ifu.sv
// rtl/rp32_ifu.sv - instruction fetch unit: fetch PC, program bus requester and prefetch FIFO
module rp32_ifu #(
    parameter int             PAW     = 32,
    parameter int             PDW     = 32,
    parameter int             FD      = 4,
    parameter logic [PAW-1:0] RST_ADR = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           bup_req,
    output logic [PAW-1:0] bup_adr,
    input  logic [PDW-1:0] bup_dat,
    input  logic           bup_ack,
    input  logic           jmp_vld,
    input  logic [PAW-1:0] jmp_adr,
    output logic           ifu_vld,
    input  logic           ifu_rdy,
    output logic [PDW-1:0] ifu_ins,
    output logic [PAW-1:0] ifu_pc
);

    localparam int             AW         = $clog2(FD);
    localparam int             CW         = AW + 1;
    localparam int             BYTES      = PDW / 8;
    localparam logic [PAW-1:0] PC_INC     = PAW'(BYTES);
    localparam logic [PAW-1:0] ALIGN_MASK = ~(PAW'(BYTES - 1));

    logic [PAW-1:0] pc;
    logic [CW-1:0]  count;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [PAW-1:0] adr_mem [FD];
    logic [PDW-1:0] ins_mem [FD];
    logic           push;
    logic           pop;

    // Full FIFO blocks fetch regardless of a concurrent pop: no bypass path.
    assign bup_req = rst_n && (count < CW'(FD)) && !jmp_vld;
    assign bup_adr = pc;
    assign push    = bup_req && bup_ack;

    assign ifu_vld = rst_n && (count != '0);
    assign pop     = ifu_vld && ifu_rdy;
    assign ifu_ins = ins_mem[rd_ptr];
    assign ifu_pc  = adr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RST_ADR;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (jmp_vld) begin
            // Redirect wins over any pop; push cannot happen since bup_req is low.
            pc     <= jmp_adr & ALIGN_MASK;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                pc     <= pc + PC_INC;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            adr_mem[wr_ptr] <= pc;
            ins_mem[wr_ptr] <= bup_dat;
        end
    end

endmodule

// File: tb/tb_rp32_ifu.sv
// tb/tb_rp32_ifu.sv - directed and randomized checks for rp32_ifu
module tb_rp32_ifu;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bup_req;
    logic [31:0] bup_adr;
    logic [31:0] bup_dat;
    logic        bup_ack;
    logic        jmp_vld;
    logic [31:0] jmp_adr;
    logic        ifu_vld;
    logic        ifu_rdy;
    logic [31:0] ifu_ins;
    logic [31:0] ifu_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Program memory model: word content derived from its address.
    assign bup_dat = bup_adr ^ K;

    rp32_ifu #(.PAW(32), .PDW(32), .FD(4), .RST_ADR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .bup_req(bup_req), .bup_adr(bup_adr), .bup_dat(bup_dat), .bup_ack(bup_ack),
        .jmp_vld(jmp_vld), .jmp_adr(jmp_adr),
        .ifu_vld(ifu_vld), .ifu_rdy(ifu_rdy), .ifu_ins(ifu_ins), .ifu_pc(ifu_pc)
    );

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; jmp_vld = 1'b0; jmp_adr = '0; bup_ack = 1'b0; ifu_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; jmp_vld = 1'b0; jmp_adr = '0; bup_ack = 1'b1; ifu_rdy = 1'b1;
        #1;
        checks++; if (bup_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bup_req); end
        @(negedge clk);
        #1;
        checks++; if (ifu_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", ifu_vld); end
        checks++; if (bup_adr !== 32'h0) begin failures++; $display("FAIL reset_adr got=%h exp=0", bup_adr); end
        rst_n = 1'b1; bup_ack = 1'b0; ifu_rdy = 1'b0;
        #1;
        checks++; if (bup_req !== 1'b1) begin failures++; $display("FAIL release_req got=%b exp=1", bup_req); end
        checks++; if (bup_adr !== 32'h0) begin failures++; $display("FAIL release_adr got=%h exp=0", bup_adr); end
    endtask

    task automatic test_stream;
        do_reset();
        bup_ack = 1'b1; ifu_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (bup_req !== 1'b1) begin failures++; $display("FAIL stream_req[%0d] got=%b exp=1", k, bup_req); end
            checks++; if (bup_adr !== 32'(4 * k)) begin failures++; $display("FAIL stream_adr[%0d] got=%h exp=%h", k, bup_adr, 32'(4 * k)); end
            if (k == 0) begin
                checks++; if (ifu_vld !== 1'b0) begin failures++; $display("FAIL stream_vld0 got=%b exp=0", ifu_vld); end
            end else begin
                checks++; if (ifu_vld !== 1'b1) begin failures++; $display("FAIL stream_vld[%0d] got=%b exp=1", k, ifu_vld); end
                checks++; if (ifu_pc !== 32'(4 * (k - 1))) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", k, ifu_pc, 32'(4 * (k - 1))); end
                checks++; if (ifu_ins !== (32'(4 * (k - 1)) ^ K)) begin failures++; $display("FAIL stream_ins[%0d] got=%h exp=%h", k, ifu_ins, 32'(4 * (k - 1)) ^ K); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full;
        do_reset();
        bup_ack = 1'b1; ifu_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bup_req !== 1'b1 || bup_adr !== 32'(4 * k)) begin failures++; $display("FAIL fill[%0d] got req=%b adr=%h exp req=1 adr=%h", k, bup_req, bup_adr, 32'(4 * k)); end
            @(negedge clk);
        end
        #1;
        checks++; if (bup_req !== 1'b0) begin failures++; $display("FAIL full_req got=%b exp=0", bup_req); end
        checks++; if (ifu_vld !== 1'b1 || ifu_pc !== 32'h0) begin failures++; $display("FAIL full_head got vld=%b pc=%h exp vld=1 pc=0", ifu_vld, ifu_pc); end
        ifu_rdy = 1'b1;
        #1;
        checks++; if (bup_req !== 1'b0) begin failures++; $display("FAIL full_pop_nobypass got=%b exp=0", bup_req); end
        @(negedge clk);
        ifu_rdy = 1'b0;
        #1;
        checks++; if (bup_req !== 1'b1 || bup_adr !== 32'h10) begin failures++; $display("FAIL refill got req=%b adr=%h exp req=1 adr=10", bup_req, bup_adr); end
        checks++; if (ifu_pc !== 32'h4) begin failures++; $display("FAIL refill_head got=%h exp=4", ifu_pc); end
        @(negedge clk);
        #1;
        checks++; if (bup_req !== 1'b0) begin failures++; $display("FAIL refull_req got=%b exp=0", bup_req); end
        bup_ack = 1'b0; ifu_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (ifu_vld !== 1'b1 || ifu_pc !== 32'(4 + 4 * k)) begin failures++; $display("FAIL drain[%0d] got vld=%b pc=%h exp vld=1 pc=%h", k, ifu_vld, ifu_pc, 32'(4 + 4 * k)); end
            @(negedge clk);
        end
        #1;
        checks++; if (ifu_vld !== 1'b0) begin failures++; $display("FAIL drained_vld got=%b exp=0", ifu_vld); end
    endtask

    task automatic test_jump;
        do_reset();
        bup_ack = 1'b1; ifu_rdy = 1'b0;
        repeat (3) @(negedge clk);
        jmp_vld = 1'b1; jmp_adr = 32'h1003;
        #1;
        checks++; if (bup_req !== 1'b0) begin failures++; $display("FAIL jump_req got=%b exp=0", bup_req); end
        checks++; if (ifu_vld !== 1'b1 || ifu_pc !== 32'h0) begin failures++; $display("FAIL jump_pre_head got vld=%b pc=%h exp vld=1 pc=0", ifu_vld, ifu_pc); end
        @(negedge clk);
        jmp_vld = 1'b0; bup_ack = 1'b0;
        #1;
        checks++; if (ifu_vld !== 1'b0) begin failures++; $display("FAIL jump_flush got=%b exp=0", ifu_vld); end
        checks++; if (bup_req !== 1'b1 || bup_adr !== 32'h1000) begin failures++; $display("FAIL jump_target got req=%b adr=%h exp req=1 adr=1000", bup_req, bup_adr); end
        bup_ack = 1'b1; ifu_rdy = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (ifu_vld !== 1'b1 || ifu_pc !== 32'h1000 || ifu_ins !== (32'h1000 ^ K)) begin failures++; $display("FAIL jump_first got vld=%b pc=%h ins=%h exp vld=1 pc=1000 ins=%h", ifu_vld, ifu_pc, ifu_ins, 32'h1000 ^ K); end
        checks++; if (bup_adr !== 32'h1004) begin failures++; $display("FAIL jump_next_adr got=%h exp=1004", bup_adr); end
    endtask

    task automatic test_wrap;
        bup_ack = 1'b1; ifu_rdy = 1'b1;
        jmp_vld = 1'b1; jmp_adr = 32'hFFFF_FFFC;
        @(negedge clk);
        jmp_vld = 1'b0;
        #1;
        checks++; if (bup_adr !== 32'hFFFF_FFFC || ifu_vld !== 1'b0) begin failures++; $display("FAIL wrap_top got adr=%h vld=%b exp adr=fffffffc vld=0", bup_adr, ifu_vld); end
        @(negedge clk);
        #1;
        checks++; if (bup_adr !== 32'h0) begin failures++; $display("FAIL wrap_adr got=%h exp=0", bup_adr); end
        checks++; if (ifu_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc0 got=%h exp=fffffffc", ifu_pc); end
        @(negedge clk);
        #1;
        checks++; if (ifu_pc !== 32'h0 || bup_adr !== 32'h4) begin failures++; $display("FAIL wrap_pc1 got pc=%h adr=%h exp pc=0 adr=4", ifu_pc, bup_adr); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bup_ack = 1'b1; ifu_rdy = 1'b0;
        jmp_vld = 1'b1; jmp_adr = 32'h200;
        @(negedge clk);
        jmp_adr = 32'h302;
        #1;
        checks++; if (bup_req !== 1'b0) begin failures++; $display("FAIL b2b_req got=%b exp=0", bup_req); end
        @(negedge clk);
        jmp_vld = 1'b0;
        #1;
        checks++; if (bup_adr !== 32'h300 || ifu_vld !== 1'b0) begin failures++; $display("FAIL b2b_target got adr=%h vld=%b exp adr=300 vld=0", bup_adr, ifu_vld); end
    endtask

    task automatic test_reset_full;
        do_reset();
        bup_ack = 1'b1; ifu_rdy = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (ifu_vld !== 1'b1 || bup_req !== 1'b0) begin failures++; $display("FAIL rstfull_pre got vld=%b req=%b exp vld=1 req=0", ifu_vld, bup_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (ifu_vld !== 1'b0 || bup_req !== 1'b0) begin failures++; $display("FAIL rstfull_during got vld=%b req=%b exp 0 0", ifu_vld, bup_req); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bup_req !== 1'b1 || bup_adr !== 32'h0 || ifu_vld !== 1'b0) begin failures++; $display("FAIL rstfull_after got req=%b adr=%h vld=%b exp req=1 adr=0 vld=0", bup_req, bup_adr, ifu_vld); end
    endtask

    task automatic test_random;
        logic [31:0] q[$];
        logic [31:0] mpc;
        logic        exp_req;
        int          fail0;
        do_reset();
        mpc = 32'h0;
        fail0 = failures;
        for (int cyc = 0; cyc < 3000 && failures == fail0; cyc++) begin
            jmp_vld = ($urandom_range(0, 19) == 0);
            jmp_adr = $urandom;
            bup_ack = $urandom_range(0, 1) == 1;
            ifu_rdy = $urandom_range(0, 1) == 1;
            #1;
            exp_req = (q.size() < 4) && !jmp_vld;
            checks++; if (bup_req !== exp_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, bup_req, exp_req); end
            if (exp_req) begin
                checks++; if (bup_adr !== mpc) begin failures++; $display("FAIL rnd_adr cyc=%0d got=%h exp=%h", cyc, bup_adr, mpc); end
            end
            checks++; if (ifu_vld !== (q.size() != 0)) begin failures++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, ifu_vld, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if (ifu_pc !== q[0] || ifu_ins !== (q[0] ^ K)) begin failures++; $display("FAIL rnd_head cyc=%0d got pc=%h ins=%h exp pc=%h ins=%h", cyc, ifu_pc, ifu_ins, q[0], q[0] ^ K); end
            end
            if (jmp_vld) begin
                q.delete();
                mpc = jmp_adr & 32'hFFFF_FFFC;
            end else begin
                if (q.size() != 0 && ifu_rdy) void'(q.pop_front());
                if (exp_req && bup_ack) begin
                    q.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
            @(negedge clk);
        end
        jmp_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; jmp_vld = 1'b0; jmp_adr = '0; bup_ack = 1'b0; ifu_rdy = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_jump();
        test_wrap();
        test_back_to_back();
        test_reset_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
